// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM states,
// forwarding select encodings and register constants.
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int         WAIT_W = 16;
endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding select for one EX operand: the youngest producer (MEM) wins over
// WB, and x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_sel
);
  fwd_sel_t w_sel;

  always_comb begin
    w_sel = FWD_RF;
    if (i_reg_write_m && (i_rd_m != REG_X0) && (i_rd_m == i_rs))
      w_sel = FWD_MEM;
    else if (i_reg_write_w && (i_rd_w != REG_X0) && (i_rd_w == i_rs))
      w_sel = FWD_WB;
  end

  assign o_sel = w_sel;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, stall/flush/bubble priority,
// data-memory wait FSM with sticky timeout, saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_rd_e,
  input  logic             i_load_e,
  input  logic [4:0]       i_rd_m,
  input  logic             i_reg_write_m,
  input  logic [4:0]       i_rd_w,
  input  logic             i_reg_write_w,
  input  logic             i_mem_access_m,
  input  logic             i_mem_ready,
  input  logic             i_pc_src_e,
  input  logic             i_perf_clr,
  output logic [1:0]       o_forward_ae,
  output logic [1:0]       o_forward_be,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_bubble_e,
  output logic             o_bubble_w,
  output logic             o_wait_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout_err
);
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         r_state, w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_stall_cycles, r_flush_count;
  logic              w_mem_stall, w_load_use, w_any_stall;
  logic [1:0][4:0]   w_rs_e;
  logic [1:0][1:0]   w_fwd;

  assign w_rs_e = {i_rs2_e, i_rs1_e};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_select u_fwd (
      .i_rs          (w_rs_e[g]),
      .i_rd_m        (i_rd_m),
      .i_reg_write_m (i_reg_write_m),
      .i_rd_w        (i_rd_w),
      .i_reg_write_w (i_reg_write_w),
      .o_sel         (w_fwd[g])
    );
  end

  assign o_forward_ae = i_rst ? w_fwd[0] : FWD_RF;
  assign o_forward_be = i_rst ? w_fwd[1] : FWD_RF;

  assign w_mem_stall = i_mem_access_m && !i_mem_ready;
  assign w_load_use  = i_load_e && (i_rd_e != REG_X0) &&
                       ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

  // Priority: memory stall freezes everything (branch re-resolves later),
  // then control flush, then load-use.
  always_comb begin
    o_stall_f  = 1'b0;
    o_stall_d  = 1'b0;
    o_stall_e  = 1'b0;
    o_stall_m  = 1'b0;
    o_flush_d  = 1'b0;
    o_bubble_e = 1'b0;
    o_bubble_w = 1'b0;
    if (i_rst) begin
      if (w_mem_stall) begin
        o_stall_f  = 1'b1;
        o_stall_d  = 1'b1;
        o_stall_e  = 1'b1;
        o_stall_m  = 1'b1;
        o_bubble_w = 1'b1;
      end else if (i_pc_src_e) begin
        o_flush_d  = 1'b1;
        o_bubble_e = 1'b1;
      end else if (w_load_use) begin
        o_stall_f  = 1'b1;
        o_stall_d  = 1'b1;
        o_bubble_e = 1'b1;
      end
    end
  end

  assign w_any_stall = o_stall_f | o_stall_d | o_stall_e | o_stall_m;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:      if (w_mem_stall)  w_next = MEM_WAIT;
      MEM_WAIT: if (!w_mem_stall) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_timeout_err  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == MEM_WAIT) && w_mem_stall) begin
        if (r_wait_cnt != '1) r_wait_cnt <= w_wait_inc;
        if (w_wait_inc >= TIMEOUT) r_timeout_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (i_perf_clr) begin
        r_stall_cycles <= '0;
        r_flush_count  <= '0;
      end else begin
        if (w_any_stall && (r_stall_cycles != '1))
          r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        if (o_flush_d && (r_flush_count != '1))
          r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign o_wait_state      = i_rst && (r_state == MEM_WAIT);
  assign o_stall_cycles    = r_stall_cycles;
  assign o_flush_count     = r_flush_count;
  assign o_mem_timeout_err = r_timeout_err;
endmodule
